// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : systolic_pkg
// Brief   : Shared constants and types for the 4x4 systolic array output stage.
// Revision: 1.0  initial release
// ============================================================================
package systolic_pkg;

    localparam int N     = 4;
    localparam int ACC_W = 32;
    localparam int OUT_W = 16;

    localparam int NN    = N * N;
    localparam int IDX_W = $clog2(NN);
    localparam int RC_W  = $clog2(N);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    typedef logic [IDX_W-1:0] tile_idx_t;
    typedef logic [RC_W-1:0]  coord_t;

endpackage
`default_nettype wire

// File: rtl/result_drain_if.sv
`default_nettype none
// ============================================================================
// Module  : result_drain_if
// Brief   : Valid/ready result stream carrying saturated elements and coordinates.
// Revision: 1.0  initial release
// ============================================================================
interface result_drain_if;
    import systolic_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    coord_t           out_row;
    coord_t           out_col;
    logic             out_last;

    modport master (
        output out_valid, out_data, out_sat, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_sat, out_row, out_col, out_last,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/sat_narrow.sv
`default_nettype none
// ============================================================================
// Module  : sat_narrow
// Brief   : Combinational signed saturating narrower, ACC_W to OUT_W bits.
// Revision: 1.0  initial release
// ============================================================================
module sat_narrow #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  wire logic [ACC_W-1:0] acc,
    output logic      [OUT_W-1:0] value,
    output logic                  sat
);

    localparam int c_HEAD_W = ACC_W - OUT_W + 1;

    logic [c_HEAD_W-1:0] w_head;
    logic                w_fits;

    // The value fits when every bit from the OUT_W sign position upward agrees.
    assign w_head = acc[ACC_W-1:OUT_W-1];
    assign w_fits = (w_head == '0) || (w_head == '1);

    always_comb begin
        sat   = ~w_fits;
        value = acc[OUT_W-1:0];
        if (!w_fits) begin
            if (acc[ACC_W-1]) value = {1'b1, {(OUT_W-1){1'b0}}};
            else              value = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
// Module  : result_drain
// Brief   : Snapshots the PE accumulators and streams them row-major, saturated.
// Revision: 1.0  initial release
// ============================================================================
module result_drain
    import systolic_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 release_output,
    input  wire logic [NN*ACC_W-1:0]  acc_in,
    result_drain_if.master            dout,
    output logic                      drain_busy,
    output logic                      drain_done,
    output logic                      overrun_err
);

    drain_state_t     r_state, w_state_nxt;
    tile_idx_t        r_idx, w_idx_nxt;
    logic [ACC_W-1:0] r_buf [NN];
    logic             r_done, r_overrun;
    logic             w_load, w_xfer, w_last, w_done_nxt, w_overrun_set;

    assign w_last = (r_idx == tile_idx_t'(NN - 1));
    assign w_xfer = (r_state == STREAM) && dout.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NN; i++) r_buf[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            if (w_overrun_set) r_overrun <= 1'b1;
            if (w_load) begin
                for (int i = 0; i < NN; i++) r_buf[i] <= acc_in[i*ACC_W +: ACC_W];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_load        = 1'b0;
        w_done_nxt    = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (release_output) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (w_xfer) begin
                    w_idx_nxt = r_idx + 1'b1;
                    if (w_last) begin
                        w_done_nxt = 1'b1;
                        // A release coinciding with the final beat chains the next tile.
                        if (release_output) begin
                            w_load    = 1'b1;
                            w_idx_nxt = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                if (release_output && !(w_xfer && w_last)) w_overrun_set = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    sat_narrow #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat_narrow (
        .acc   (r_buf[r_idx]),
        .value (dout.out_data),
        .sat   (dout.out_sat)
    );

    // N is a power of two, so row/col are the upper/lower halves of idx.
    assign dout.out_valid = (r_state == STREAM);
    assign dout.out_row   = r_idx[IDX_W-1:RC_W];
    assign dout.out_col   = r_idx[RC_W-1:0];
    assign dout.out_last  = (r_state == STREAM) && w_last;

    assign drain_busy  = (r_state == STREAM);
    assign drain_done  = r_done;
    assign overrun_err = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
// Module  : tb_result_drain
// Brief   : Directed and randomized bench for result_drain against a beat-queue model.
// Revision: 1.0  initial release
// ============================================================================
module tb_result_drain;
    import systolic_pkg::*;

    typedef struct {
        int idx;
        int val;
    } beat_t;

    logic                clk;
    logic                rst;
    logic                release_output;
    logic [NN*ACC_W-1:0] acc_in;
    logic                drain_busy;
    logic                drain_done;
    logic                overrun_err;

    result_drain_if dif ();

    result_drain dut (
        .clk            (clk),
        .rst            (rst),
        .release_output (release_output),
        .acc_in         (acc_in),
        .dout           (dif),
        .drain_busy     (drain_busy),
        .drain_done     (drain_done),
        .overrun_err    (overrun_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    checks = 0;
    int    errors = 0;
    beat_t q[$];
    int    cur_tile [16];
    bit    exp_done = 1'b0;
    bit    exp_ovr  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic void sat_ref(input int v, output int o, output bit s);
        if (v > 32767)       begin o = 32767;  s = 1'b1; end
        else if (v < -32768) begin o = -32768; s = 1'b1; end
        else                 begin o = v;      s = 1'b0; end
    endfunction

    task automatic rand_tile();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) cur_tile[i] = int'($urandom());
            else                           cur_tile[i] = int'($urandom_range(0, 80000)) - 40000;
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input bit rel, input bit rdy);
        bit mvalid, xfer, accept;
        int sv;
        bit ss;
        release_output = rel;
        dif.out_ready  = rdy;
        for (int i = 0; i < 16; i++)
            acc_in[i*32 +: 32] = rel ? 32'(cur_tile[i]) : 32'($urandom());
        #1;
        mvalid = (q.size() > 0);
        chk("valid",   32'(dif.out_valid), 32'(mvalid));
        chk("busy",    32'(drain_busy),    32'(mvalid));
        chk("done",    32'(drain_done),    32'(exp_done));
        chk("overrun", 32'(overrun_err),   32'(exp_ovr));
        if (mvalid) begin
            sat_ref(q[0].val, sv, ss);
            chk("data", int'($signed(dif.out_data)), sv);
            chk("sat",  32'(dif.out_sat),  32'(ss));
            chk("row",  32'(dif.out_row),  q[0].idx / 4);
            chk("col",  32'(dif.out_col),  q[0].idx % 4);
            chk("last", 32'(dif.out_last), 32'(q[0].idx == 15));
        end else begin
            chk("last_idle", 32'(dif.out_last), 32'd0);
        end
        xfer     = mvalid && rdy;
        exp_done = 1'b0;
        if (xfer) exp_done = (q[0].idx == 15);
        accept = rel && ((q.size() == 0) || (xfer && q.size() == 1));
        if (rel && !accept) exp_ovr = 1'b1;
        if (xfer) void'(q.pop_front());
        if (accept) for (int i = 0; i < 16; i++) q.push_back('{i, cur_tile[i]});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        release_output = 1'b0;
        dif.out_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_busy",  32'(drain_busy),    32'd0);
        chk("rst_done",  32'(drain_done),    32'd0);
        chk("rst_ovr",   32'(overrun_err),   32'd0);
        chk("rst_data",  32'(dif.out_data),  32'd0);
        chk("rst_sat",   32'(dif.out_sat),   32'd0);
        chk("rst_row",   32'(dif.out_row),   32'd0);
        chk("rst_col",   32'(dif.out_col),   32'd0);
        chk("rst_last",  32'(dif.out_last),  32'd0);
        rst = 1'b0;
        q.delete();
        exp_done = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1.
    task automatic drain(input int mode);
        for (int k = 0; k < 100 && q.size() > 0; k++)
            cycle(1'b0, (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3)));
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
    endtask

    initial begin
        rst            = 1'b1;
        release_output = 1'b0;
        acc_in         = '0;
        dif.out_ready  = 1'b0;
        @(negedge clk);
        do_reset();
        cycle(1'b0, 1'b1);

        // Basic drain: acc(r,c) = 10*r + c
        for (int i = 0; i < 16; i++) cur_tile[i] = 10 * (i / 4) + (i % 4);
        cycle(1'b1, 1'b1);
        drain(0);

        // Saturation boundaries
        rand_tile();
        cur_tile[0] = 40000;
        cur_tile[1] = -40000;
        cur_tile[2] = 32767;
        cur_tile[3] = -32768;
        cycle(1'b1, 1'b1);
        drain(0);

        // Backpressure
        rand_tile();
        cycle(1'b1, 1'b1);
        drain(1);

        // Overrun at beat 5: original tile must complete, error sticks
        rand_tile();
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 40 && q.size() > 0 && q[0].idx != 5; k++) cycle(1'b0, 1'b1);
        begin
            int saved [16];
            saved = cur_tile;
            rand_tile();
            cycle(1'b1, 1'b1);
            cur_tile = saved;
        end
        drain(0);
        chk("overrun_sticky", 32'(overrun_err), 32'd1);
        do_reset();

        // Back-to-back tiles
        rand_tile();
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 40 && q.size() > 1; k++) cycle(1'b0, 1'b1);
        rand_tile();
        cycle(1'b1, 1'b1);
        drain(0);
        chk("b2b_no_overrun", 32'(overrun_err), 32'd0);

        // Reset at beat 7, then a fresh tile
        rand_tile();
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 40 && q.size() > 0 && q[0].idx != 7; k++) cycle(1'b0, 1'b1);
        do_reset();
        cycle(1'b0, 1'b1);
        rand_tile();
        cycle(1'b1, 1'b1);
        drain(0);

        // Random releases and random backpressure
        for (int t = 0; t < 6; t++) begin
            rand_tile();
            cycle(1'b1, 1'($urandom_range(0, 1)));
            for (int k = 0; k < 60; k++) begin
                bit rel;
                rel = ($urandom_range(0, 15) == 0);
                if (rel) rand_tile();
                cycle(rel, ($urandom_range(0, 2) != 0));
            end
            drain(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
